spec_dpram_readout_ctrl: RTL and testbench

- Schedules readout of the accumulated power-spectrum DPRAM (range bins x FFT bins, 32-bit words) once a pulse group completes.
- Arbitrates the DPRAM read port (addrb) between the spectrum accumulator's read-modify-write path (absolute priority) and the readout streamer.
- Presents a valid/ready output stream to the capture/output path.

---
 rtl/spec_dpram_readout_ctrl.sv | 177 +++++++++++++++++
 tb/tb_spec_dpram_readout_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spec_dpram_readout_ctrl.sv
// -----------------------------------------------------------------------------
// spec_dpram_readout_ctrl
//
// Streams the accumulated power-spectrum DPRAM (range bins x FFT bins) out
// through a valid/ready interface once a pulse group completes. The DPRAM
// read port B is shared with the spectrum accumulator's read-modify-write
// path, which always wins; the readout simply stalls on those cycles.
//
// Optional build macro: READOUT_CLEAR_EN
//   defined   : each word captured from the DPRAM is followed one cycle later
//               by a port-A clear request (clr_we_o / clr_addr_o).
//   undefined : clr_we_o / clr_addr_o are tied to 0.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   group_done_i      one-cycle pulse, starts a dump of nbins_i range bins
//   nbins_i           range bins to dump (1..16), sampled at start
//   acc_rd_req_i      accumulator owns port B this cycle
//   acc_rdaddr_i      accumulator read address
//   dpram_addrb_o     DPRAM port B address
//   dpram_doutb_i     DPRAM port B data (1-cycle latency)
//   dout_o            stream data
//   dout_valid_o      stream valid
//   dout_ready_i      stream ready
//   dout_last_o       final word of the dump
//   busy_o            dump in progress
//   overrun_o         sticky: group_done_i seen while busy
//   clr_we_o          port-A clear write enable
//   clr_addr_o        port-A clear address
// -----------------------------------------------------------------------------
module spec_dpram_readout_ctrl #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int NFFT_LOG2 = 10,
  parameter int BIN_W     = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              group_done_i,
  input  logic [BIN_W-1:0]  nbins_i,
  input  logic              acc_rd_req_i,
  input  logic [ADDR_W-1:0] acc_rdaddr_i,
  output logic [ADDR_W-1:0] dpram_addrb_o,
  input  logic [DATA_W-1:0] dpram_doutb_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_valid_o,
  input  logic              dout_ready_i,
  output logic              dout_last_o,
  output logic              busy_o,
  output logic              overrun_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam int BANK_W = ADDR_W - NFFT_LOG2;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [BANK_W-1:0]     bin_reg;
  logic [NFFT_LOG2-1:0]  idx_reg;
  logic [BIN_W-1:0]      last_bin_reg;
  logic                  inflight_reg;
  logic [ADDR_W-1:0]     inflight_addr_reg;
  logic                  inflight_last_reg;
  logic [DATA_W-1:0]     buf_data_reg [2];
  logic                  buf_last_reg [2];
  logic                  wr_ptr_reg, rd_ptr_reg;
  logic [1:0]            count_reg;
  logic                  overrun_reg;

  logic [ADDR_W-1:0]     rd_addr;
  logic                  at_last_addr;
  logic                  pop;
  logic [1:0]            occ_after_pop;
  logic                  credit_ok;
  logic                  issue;
  logic                  start;

  assign rd_addr      = {bin_reg, idx_reg};
  assign at_last_addr = (BIN_W'(bin_reg) == last_bin_reg) && (idx_reg == '1);
  assign pop          = (count_reg != 2'd0) && dout_ready_i;
  // A slot freed by this cycle's pop counts as a credit, otherwise the
  // buffer could never sustain one word per cycle.
  assign occ_after_pop = count_reg + {1'b0, inflight_reg} - {1'b0, pop};
  assign credit_ok    = (occ_after_pop < 2'd2);
  assign issue        = (state_reg == READ) && !acc_rd_req_i && credit_ok;
  assign start        = (state_reg == IDLE) && group_done_i && (nbins_i != '0);

  // Accumulator has absolute priority on port B in every state.
  assign dpram_addrb_o = acc_rd_req_i ? acc_rdaddr_i : rd_addr;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = READ;
      READ:    if (issue && at_last_addr) state_next = DRAIN;
      DRAIN:   if ((count_reg == 2'd0) && !inflight_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg         <= IDLE;
      bin_reg           <= '0;
      idx_reg           <= '0;
      last_bin_reg      <= '0;
      inflight_reg      <= 1'b0;
      inflight_addr_reg <= '0;
      inflight_last_reg <= 1'b0;
      wr_ptr_reg        <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      count_reg         <= 2'd0;
      overrun_reg       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data_reg[i] <= '0;
        buf_last_reg[i] <= 1'b0;
      end
    end else begin
      state_reg <= state_next;

      if (start) begin
        {bin_reg, idx_reg} <= '0;
        last_bin_reg       <= nbins_i - BIN_W'(1);
      end else if (issue) begin
        {bin_reg, idx_reg} <= rd_addr + ADDR_W'(1);
      end

      inflight_reg <= issue;
      if (issue) begin
        inflight_addr_reg <= rd_addr;
        inflight_last_reg <= at_last_addr;
      end

      if (inflight_reg) begin
        buf_data_reg[wr_ptr_reg] <= dpram_doutb_i;
        buf_last_reg[wr_ptr_reg] <= inflight_last_reg;
        wr_ptr_reg               <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, inflight_reg} - {1'b0, pop};

      if (group_done_i && (state_reg != IDLE)) overrun_reg <= 1'b1;
    end
  end

  assign dout_valid_o = (count_reg != 2'd0);
  assign dout_o       = buf_data_reg[rd_ptr_reg];
  assign dout_last_o  = dout_valid_o && buf_last_reg[rd_ptr_reg];
  assign busy_o       = (state_reg != IDLE);
  assign overrun_o    = overrun_reg;

`ifdef READOUT_CLEAR_EN
  logic              clr_pend_reg;
  logic [ADDR_W-1:0] clr_addr_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clr_pend_reg <= 1'b0;
      clr_addr_reg <= '0;
    end else begin
      clr_pend_reg <= inflight_reg;
      if (inflight_reg) clr_addr_reg <= inflight_addr_reg;
    end
  end

  // The accumulator's RMW traffic owns the port-A mux on its active cycles,
  // so the clear request is dropped there rather than fighting it.
  assign clr_we_o   = clr_pend_reg && !acc_rd_req_i;
  assign clr_addr_o = clr_addr_reg;
`else
  assign clr_we_o   = 1'b0;
  assign clr_addr_o = '0;
`endif

endmodule

// File: tb/tb_spec_dpram_readout_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for spec_dpram_readout_ctrl. A DPRAM model returns data equal to
// the address. Expected words are queued when a dump is started and a monitor
// pops and compares them on every stream handshake.
// -----------------------------------------------------------------------------
module tb_spec_dpram_readout_ctrl;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int NFFT   = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              group_done = 1'b0;
  logic [4:0]        nbins = 5'd0;
  logic              acc_rd_req = 1'b0;
  logic [ADDR_W-1:0] acc_rdaddr = 14'h1234;
  logic [ADDR_W-1:0] dpram_addrb;
  logic [DATA_W-1:0] dpram_doutb = '0;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready = 1'b1;
  logic              dout_last;
  logic              busy;
  logic              overrun;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bit rand_ready = 0;
  bit contend    = 0;

  logic [DATA_W:0] exp_q [$];  // {last, data}
  int  words    = 0;
  bit  saw_last = 0;
  int  contended = 0;
  int  clr_cnt  = 0;
  int  clr_total = 0;
  int  clr_seen [NFFT];

  bit              have_prev = 0;
  logic [DATA_W-1:0] prev_data;
  logic            prev_last;

  spec_dpram_readout_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .group_done_i  (group_done),
    .nbins_i       (nbins),
    .acc_rd_req_i  (acc_rd_req),
    .acc_rdaddr_i  (acc_rdaddr),
    .dpram_addrb_o (dpram_addrb),
    .dpram_doutb_i (dpram_doutb),
    .dout_o        (dout),
    .dout_valid_o  (dout_valid),
    .dout_ready_i  (dout_ready),
    .dout_last_o   (dout_last),
    .busy_o        (busy),
    .overrun_o     (overrun),
    .clr_we_o      (clr_we),
    .clr_addr_o    (clr_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // DPRAM port B model: registered read, data = address.
  always @(posedge clk) dpram_doutb <= {{(DATA_W-ADDR_W){1'b0}}, dpram_addrb};

  // Background drivers for ready and accumulator contention.
  always @(posedge clk) begin
    #1;
    dout_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    acc_rd_req = contend && (cyc % 4 == 0);
  end

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      have_prev = 0;
    end else begin
      if (acc_rd_req) begin
        contended++;
        chk("arb_addr", 32'(dpram_addrb), 32'(acc_rdaddr));
      end
      if (have_prev) begin
        chk("hold_valid", 32'(dout_valid), 32'd1);
        chk("hold_data", dout, prev_data);
        chk("hold_last", 32'(dout_last), 32'(prev_last));
      end
      have_prev = dout_valid && !dout_ready;
      prev_data = dout;
      prev_last = dout_last;
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_word: got %0h expected none", dout);
        end else begin
          logic [DATA_W:0] e;
          e = exp_q.pop_front();
          chk("word_data", dout, e[DATA_W-1:0]);
          chk("word_last", 32'(dout_last), 32'(e[DATA_W]));
        end
        words++;
        if (dout_last) saw_last = 1;
      end
      if (clr_we) begin
        clr_cnt++;
        clr_total++;
        if (clr_addr < ADDR_W'(NFFT)) clr_seen[clr_addr]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_dump(input int nb);
    words    = 0;
    saw_last = 0;
    for (int a = 0; a < nb * NFFT; a++)
      exp_q.push_back({(a == nb * NFFT - 1), 32'(a)});
  endtask

  // Leaves the caller at #1 into the first cycle after the pulse edge.
  task automatic pulse(input int nb);
    @(posedge clk);
    #1;
    nbins      = 5'(nb);
    group_done = 1'b1;
    @(posedge clk);
    #1;
    group_done = 1'b0;
  endtask

  task automatic wait_dump(input string name, input int nwords);
    int n = 0;
    while (!(saw_last && exp_q.size() == 0) && n < 20000) begin
      tick();
      n++;
    end
    if (n >= 20000) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got %0d words expected %0d", name, words, nwords);
    end else begin
      chk({name, "_busy_drain"}, 32'(busy), 32'd1);
      tick();
      chk({name, "_busy_idle"}, 32'(busy), 32'd0);
    end
    chk({name, "_words"}, 32'(words), 32'(nwords));
    $display("dump %s: %0d words, overrun=%0b, contended cycles=%0d",
             name, words, overrun, contended);
  endtask

  task automatic wait_words(input int target);
    int n = 0;
    while (words < target && n < 20000) begin
      tick();
      n++;
    end
    if (n >= 20000) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_words: got %0d expected %0d", words, target);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, 32'(dout_valid), 32'd0);
    chk({name, "_last"}, 32'(dout_last), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_overrun"}, 32'(overrun), 32'd0);
    chk({name, "_dout"}, dout, 32'd0);
    chk({name, "_clr_we"}, 32'(clr_we), 32'd0);
    chk({name, "_clr_addr"}, 32'(clr_addr), 32'd0);
    chk({name, "_addrb"}, 32'(dpram_addrb), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NFFT; i++) clr_seen[i] = 0;

    // Reset values.
    repeat (3) tick();
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // nbins=0 pulse is ignored.
    pulse(0);
    #1;
    chk("nbins0_busy", 32'(busy), 32'd0);
    tick();
    chk("nbins0_valid", 32'(dout_valid), 32'd0);

    // Dump 1: two bins, no contention, ready high; latency check.
    push_dump(2);
    pulse(2);
    #1;
    chk("lat_c1_valid", 32'(dout_valid), 32'd0);
    chk("lat_c1_busy", 32'(busy), 32'd1);
    tick();
    chk("lat_c2_valid", 32'(dout_valid), 32'd0);
    tick();
    chk("lat_c3_valid", 32'(dout_valid), 32'd1);
    wait_dump("plain", 2048);

    // Dump 2: accumulator steals port B every 4th cycle.
    contended = 0;
    contend   = 1;
    push_dump(2);
    pulse(2);
    wait_dump("contend", 2048);
    contend = 0;
    n_vec++;
    if (contended < 100) begin
      n_err++;
      $display("FAIL contend_cycles: got %0d expected >= 100", contended);
    end

    // Dump 3: random ready.
    rand_ready = 1;
    push_dump(2);
    pulse(2);
    wait_dump("randready", 2048);

    // Dump 4: second pulse mid-dump raises sticky overrun.
    chk("overrun_before", 32'(overrun), 32'd0);
    push_dump(2);
    pulse(2);
    wait_words(500);
    pulse(2);
    #1;
    chk("overrun_set", 32'(overrun), 32'd1);
    wait_dump("overrun", 2048);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    rand_ready = 0;

    // Dump 5: reset at word 700, then a clean single-bin dump.
    push_dump(2);
    pulse(2);
    wait_words(700);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk_all_zero("midreset");
    exp_q.delete();
    tick();
    chk_all_zero("midreset_edge");
    @(posedge clk);
    #1 rst = 1'b0;
    clr_cnt = 0;
    for (int i = 0; i < NFFT; i++) clr_seen[i] = 0;
    push_dump(1);
    pulse(1);
    wait_dump("after_reset", 1024);
    chk("after_reset_overrun", 32'(overrun), 32'd0);

`ifdef READOUT_CLEAR_EN
    begin
      int bad = 0;
      tick();
      for (int i = 0; i < NFFT; i++) if (clr_seen[i] != 1) bad++;
      chk("clr_pulses", 32'(clr_cnt), 32'd1024);
      chk("clr_addr_once", 32'(bad), 32'd0);
    end
`else
    chk("clr_never", 32'(clr_total), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
